// File: rtl/seg_display_mux.sv
// Scans a 4-digit common-anode 7-segment display showing MM.SS from filtered counter values,
// blinking the selected field while in adjust mode.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    DIG_S1  = 2'd0,
    DIG_S10 = 2'd1,
    DIG_M1  = 2'd2,
    DIG_M10 = 2'd3
  } digit_e;

  logic [11:0]   samp_q, samp_d, held_q, held_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [BW-1:0] blk_q, blk_d;
  digit_e        idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          adj_q;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [5:0] field_v;
  logic [7:0] bcd;
  logic [3:0] nib;
  logic       blank;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    if      (v >= 6'd50) t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    // ones fit in 4 bits, so modulo-16 subtraction yields the exact remainder
    return {t, v[3:0] - t * 4'd10};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    samp_d = {minutes, seconds};
    held_d = (samp_q == {minutes, seconds}) ? samp_q : held_q;

    ref_d = ref_q + RW'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = digit_e'(idx_q + 2'd1);
    end

    blk_d   = blk_q + BW'(1);
    phase_d = phase_q;
    if (adj && !adj_q) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (blk_q == BLK_LAST) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end

    field_v = idx_q[1] ? held_q[11:6] : held_q[5:0];
    bcd     = to_bcd(field_v);
    nib     = idx_q[0] ? bcd[7:4] : bcd[3:0];
    if (field_v >= 6'd60) seg_d = 8'hBF;
    else                  seg_d = {idx_q != DIG_M1, seg7(nib)};

    // Uses the upcoming phase so the field is visible on the very cycle adj rises.
    blank = adj && phase_d && (sel ? !idx_q[1] : idx_q[1]);
    an_d  = blank ? '1 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= '0;
      held_q  <= '0;
      ref_q   <= '0;
      blk_q   <= '0;
      idx_q   <= DIG_S1;
      phase_q <= 1'b0;
      adj_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      samp_q  <= samp_d;
      held_q  <= held_d;
      ref_q   <= ref_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      adj_q   <= adj;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed self-checking bench for seg_display_mux with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] seg1234 [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
  logic [7:0] seg5959 [4] = '{8'h90, 8'h92, 8'h10, 8'h92};
  logic [7:0] seg1260 [4] = '{8'hBF, 8'hBF, 8'h24, 8'hF9};

  seg_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
    .adj(adj), .sel(sel), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] an_of(input int d, input bit blank);
    logic [3:0] a;
    a = 4'b1111;
    if (!blank) a[d] = 1'b0;
    return a;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    minutes = 6'd0; seconds = 6'd0; adj = 1'b0; sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want FF", seg); end
    rst = 1'b0;
    cyc = -1;
    step();
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL release_an: got %b want 1110", an); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL release_seg: got %h want C0", seg); end
  endtask

  task automatic test_scan();
    int d;
    minutes = 6'd12; seconds = 6'd34;
    reset_dut();
    repeat (16) step();
    for (int k = 0; k < 20; k++) begin
      step();
      d = (cyc / 4) % 4;
      checks++;
      if (an !== an_of(d, 1'b0)) begin
        errors++; $display("FAIL scan_an cyc=%0d: got %b want %b", cyc, an, an_of(d, 1'b0));
      end
      checks++;
      if (seg !== seg1234[d]) begin
        errors++; $display("FAIL scan_seg cyc=%0d: got %h want %h", cyc, seg, seg1234[d]);
      end
    end
  endtask

  task automatic test_glitch();
    int d;
    for (int k = 0; k < 18; k++) begin
      seconds = (k == 0) ? 6'd7 : 6'd34;
      step();
      d = (cyc / 4) % 4;
      checks++;
      if (seg !== seg1234[d] || an !== an_of(d, 1'b0)) begin
        errors++; $display("FAIL glitch cyc=%0d: got an=%b seg=%h want an=%b seg=%h",
                           cyc, an, seg, an_of(d, 1'b0), seg1234[d]);
      end
    end
  endtask

  task automatic test_dash();
    int d;
    seconds = 6'd60;
    repeat (3) step();
    for (int k = 0; k < 16; k++) begin
      step();
      d = (cyc / 4) % 4;
      checks++;
      if (seg !== seg1260[d] || an !== an_of(d, 1'b0)) begin
        errors++; $display("FAIL dash cyc=%0d: got an=%b seg=%h want an=%b seg=%h",
                           cyc, an, seg, an_of(d, 1'b0), seg1260[d]);
      end
    end
    seconds = 6'd34;
    repeat (3) step();
  endtask

  task automatic test_blink();
    int  d;
    bit  blank;
    adj = 1'b1; sel = 1'b1;
    for (int j = 0; j < 48; j++) begin
      if (j == 16) sel = 1'b0;
      if (j == 32) adj = 1'b0;
      step();
      d = (cyc / 4) % 4;
      blank = adj && (((j / 8) % 2) == 1) && (sel ? (d < 2) : (d >= 2));
      checks++;
      if (an !== an_of(d, blank)) begin
        errors++; $display("FAIL blink_an j=%0d sel=%0b: got %b want %b", j, sel, an, an_of(d, blank));
      end
      if (!blank) begin
        checks++;
        if (seg !== seg1234[d]) begin
          errors++; $display("FAIL blink_seg j=%0d: got %h want %h", j, seg, seg1234[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int g = 0; g < 16 && (cyc % 16) != 9; g++) step();
    checks++;
    if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an: got %b want 1011", an); end
    rst = 1'b1;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      errors++; $display("FAIL mid_reset: got an=%b seg=%h want an=1111 seg=FF", an, seg);
    end
    rst = 1'b0;
    cyc = -1;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      errors++; $display("FAIL mid_restart0: got an=%b seg=%h want an=1110 seg=C0", an, seg);
    end
    step();
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 8'h99) begin
      errors++; $display("FAIL mid_restart2: got an=%b seg=%h want an=1110 seg=99", an, seg);
    end
    step();
    step();
    checks++;
    if (an !== 4'b1101 || seg !== 8'hB0) begin
      errors++; $display("FAIL mid_restart4: got an=%b seg=%h want an=1101 seg=B0", an, seg);
    end
  endtask

  task automatic test_5959();
    int d;
    minutes = 6'd59; seconds = 6'd59;
    repeat (3) step();
    for (int k = 0; k < 16; k++) begin
      step();
      d = (cyc / 4) % 4;
      checks++;
      if (seg !== seg5959[d] || an !== an_of(d, 1'b0)) begin
        errors++; $display("FAIL max_value cyc=%0d: got an=%b seg=%h want an=%b seg=%h",
                           cyc, an, seg, an_of(d, 1'b0), seg5959[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_dash();
    test_blink();
    test_reset_mid();
    test_5959();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
